// File: rtl/rtype_encoder.sv
// rtype_encoder: packs R-type instruction fields into RV32I words (opcode 7'b0110011),
// rejects illegal funct7/funct3 combinations, and buffers legal words in a show-ahead
// FIFO that drains into the instruction-memory write port at an incrementing address.
//
// Ports:
//   clk, rst_n           rising-edge clock, synchronous active-low reset
//   in_valid / in_ready  field-set handshake (in_ready = FIFO not full)
//   funct7..rd, in_last  instruction fields; in_last marks the end of a program
//   mem_valid/mem_ready  write handshake toward instruction memory
//   mem_addr, mem_wdata  address/word of the FIFO head
//   err                  one-cycle pulse: illegal field set was dropped
//   done                 one-cycle pulse: last instruction of a program was written
//   count                FIFO occupancy
module rtype_encoder #(
  parameter int unsigned       DEPTH     = 4,
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [6:0]                 funct7,
  input  logic [4:0]                 rs2,
  input  logic [4:0]                 rs1,
  input  logic [2:0]                 funct3,
  input  logic [4:0]                 rd,
  input  logic                       in_last,
  output logic                       mem_valid,
  input  logic                       mem_ready,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [31:0]                mem_wdata,
  output logic                       err,
  output logic                       done,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned    PtrW    = $clog2(DEPTH);
  localparam int unsigned    CntW    = $clog2(DEPTH+1);
  localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);
  localparam logic [6:0]     OpcOp   = 7'b0110011;

  // Only the 25 variable field bits are stored; the fixed opcode is appended on read.
  logic [24:0]      fields_q [DEPTH];
  logic [DEPTH-1:0] last_q;

  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              err_q, err_d;
  logic              done_q, done_d;

  logic legal;
  logic accept;
  logic push;
  logic pop;
  logic head_last;

  // funct7 = 0 covers ADD/SLL/SLT/SLTU/XOR/SRL/OR/AND; 0x20 only SUB and SRA.
  always_comb begin
    legal = 1'b0;
    if (funct7 == 7'h00) begin
      legal = 1'b1;
    end else if (funct7 == 7'h20) begin
      legal = (funct3 == 3'b000) || (funct3 == 3'b101);
    end
  end

  assign in_ready  = (count_q != FullCnt);
  assign mem_valid = (count_q != '0);
  assign accept    = in_valid && in_ready;
  assign push      = accept && legal;
  assign pop       = mem_valid && mem_ready;
  assign head_last = last_q[rd_ptr_q];

  assign mem_wdata = {fields_q[rd_ptr_q], OpcOp};
  assign mem_addr  = addr_q;
  assign err       = err_q;
  assign done      = done_q;
  assign count     = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    addr_d   = addr_q;
    err_d    = accept && !legal;
    done_d   = pop && head_last;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
      // End of a program restarts the next one at the base address.
      addr_d   = head_last ? BASE_ADDR : addr_q + ADDR_W'(4);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      addr_q   <= BASE_ADDR;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      addr_q   <= addr_d;
      err_q    <= err_d;
      done_q   <= done_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fields_q[wr_ptr_q] <= {funct7, rs2, rs1, funct3, rd};
      last_q[wr_ptr_q]   <= in_last;
    end
  end

endmodule
